// File: rtl/rf_pkg.sv
// Shared types and the write-port priority helper for the multi-port register file.
// Containers are sized for the widest supported build (DATA_W <= 64, ADDR_W <= 16, NUM_WR <= 2).
package rf_pkg;

    localparam int RF_DATA_W     = 32;
    localparam int RF_DEPTH      = 32;
    localparam int RF_MAX_DATA_W = 64;
    localparam int RF_MAX_ADDR_W = 16;
    localparam int RF_MAX_WR     = 2;

    typedef logic [RF_MAX_ADDR_W-1:0] rf_addr_t;
    typedef logic [RF_MAX_DATA_W-1:0] rf_data_t;

    typedef struct packed {
        logic     hit;
        rf_data_t data;
    } rf_hit_t;

    // Later ports overwrite earlier matches, so the highest-index writer wins.
    function automatic rf_hit_t wr_winner(
        input logic [RF_MAX_WR-1:0] en,
        input rf_addr_t [RF_MAX_WR-1:0] addr,
        input rf_data_t [RF_MAX_WR-1:0] data,
        input rf_addr_t raddr
    );
        rf_hit_t r;
        r.hit  = 1'b0;
        r.data = '0;
        for (int j = 0; j < RF_MAX_WR; j++) begin
            if (en[j] && (addr[j] == raddr)) begin
                r.hit  = 1'b1;
                r.data = data[j];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rf_multiport_if.sv
// Read/write port bundle of the multi-port register file.
// Scoreboard signals exist only when RF_SCOREBOARD_EN is defined.
interface rf_multiport_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 1
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic [NUM_RD-1:0]        rd_en;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_WR-1:0]        wr_en;
    logic [NUM_WR*ADDR_W-1:0] wr_addr;
    logic [NUM_WR*DATA_W-1:0] wr_data;
`ifdef RF_SCOREBOARD_EN
    logic                     sb_set_en;
    logic [ADDR_W-1:0]        sb_set_addr;
    logic [NUM_RD-1:0]        rd_busy;

    modport master (
        output rd_en, rd_addr, wr_en, wr_addr, wr_data, sb_set_en, sb_set_addr,
        input  rd_data, rd_busy
    );
    modport slave (
        input  rd_en, rd_addr, wr_en, wr_addr, wr_data, sb_set_en, sb_set_addr,
        output rd_data, rd_busy
    );
`else
    modport master (
        output rd_en, rd_addr, wr_en, wr_addr, wr_data,
        input  rd_data
    );
    modport slave (
        input  rd_en, rd_addr, wr_en, wr_addr, wr_data,
        output rd_data
    );
`endif

endinterface

// File: rtl/rf_read_port.sv
// One registered read port: write-through bypass, zero-register masking, enable-hold output.
// The busy flag output is present only when RF_SCOREBOARD_EN is defined.
module rf_read_port
    import rf_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       rd_en,
    input  logic [ADDR_W-1:0]          rd_addr,
    input  logic [DATA_W-1:0]          arr_data,
    input  logic [RF_MAX_WR-1:0]       wr_en_w,
    input  rf_addr_t [RF_MAX_WR-1:0]   wr_addr_w,
    input  rf_data_t [RF_MAX_WR-1:0]   wr_data_w,
`ifdef RF_SCOREBOARD_EN
    input  logic                       busy_bit,
    output logic                       rd_busy,
`endif
    output logic [DATA_W-1:0]          rd_data
);

    rf_hit_t           hit;
    logic              is_zero;
    logic [DATA_W-1:0] rd_data_next;
    logic              unused_hit_bits;

    assign hit     = wr_winner(wr_en_w, wr_addr_w, wr_data_w, rf_addr_t'(rd_addr));
    assign is_zero = (ZERO_REG != 0) && (rd_addr == '0);

    // Upper container bits beyond DATA_W are always zero-padded by the top.
    assign unused_hit_bits = ^hit.data;

    always_comb begin
        rd_data_next = arr_data;
        if (is_zero) begin
            rd_data_next = '0;
        end else if (hit.hit) begin
            rd_data_next = hit.data[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= rd_data_next;
        end
    end

`ifdef RF_SCOREBOARD_EN
    // A same-edge write clears the bit, so report it as already free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_busy <= 1'b0;
        end else if (rd_en) begin
            rd_busy <= !is_zero && !hit.hit && busy_bit;
        end
    end
`endif

endmodule

// File: rtl/rf_multiport.sv
// Parametrised multi-read/multi-write register file with registered, bypassed reads.
// Optional per-register busy scoreboard enabled by defining RF_SCOREBOARD_EN.
module rf_multiport
    import rf_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int DEPTH    = RF_DEPTH,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic clk,
    input  logic reset_n,
    rf_multiport_if.slave bus
);

    // Reset asserts asynchronously and is released two edges later.
    logic [1:0] rst_sync_reg;
    logic       rst_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync_reg <= '0;
        end else begin
            rst_sync_reg <= {rst_sync_reg[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_reg[1];

    logic [RF_MAX_WR-1:0]     wr_en_w;
    rf_addr_t [RF_MAX_WR-1:0] wr_addr_w;
    rf_data_t [RF_MAX_WR-1:0] wr_data_w;
    logic                     unused_wr_bits;

    always_comb begin
        wr_en_w   = '0;
        wr_addr_w = '0;
        wr_data_w = '0;
        for (int j = 0; j < NUM_WR; j++) begin
            wr_en_w[j]   = bus.wr_en[j];
            wr_addr_w[j] = rf_addr_t'(bus.wr_addr[j*ADDR_W +: ADDR_W]);
            wr_data_w[j] = rf_data_t'(bus.wr_data[j*DATA_W +: DATA_W]);
        end
    end

    assign unused_wr_bits = ^{wr_addr_w, wr_data_w};

    logic [DATA_W-1:0] regs_reg [DEPTH];

    // Ports are visited in ascending order, so the last matching port wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_reg[i] <= '0;
            end
        end else begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_en_w[j] && !((ZERO_REG != 0) && (wr_addr_w[j][ADDR_W-1:0] == '0))) begin
                    regs_reg[wr_addr_w[j][ADDR_W-1:0]] <= wr_data_w[j][DATA_W-1:0];
                end
            end
        end
    end

`ifdef RF_SCOREBOARD_EN
    logic [DEPTH-1:0] busy_reg;

    // The set is applied after the clears so a new producer wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_reg <= '0;
        end else begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_en_w[j]) begin
                    busy_reg[wr_addr_w[j][ADDR_W-1:0]] <= 1'b0;
                end
            end
            if (bus.sb_set_en && !((ZERO_REG != 0) && (bus.sb_set_addr == '0))) begin
                busy_reg[bus.sb_set_addr] <= 1'b1;
            end
        end
    end
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [ADDR_W-1:0] ra;
            logic [DATA_W-1:0] arr_data;
            logic [DATA_W-1:0] rd_data_w;
`ifdef RF_SCOREBOARD_EN
            logic              rd_busy_w;
`endif

            assign ra       = bus.rd_addr[gi*ADDR_W +: ADDR_W];
            assign arr_data = regs_reg[ra];

            rf_read_port #(
                .DATA_W   (DATA_W),
                .ADDR_W   (ADDR_W),
                .ZERO_REG (ZERO_REG)
            ) u_port (
                .clk       (clk),
                .rst_n     (rst_n),
                .rd_en     (bus.rd_en[gi]),
                .rd_addr   (ra),
                .arr_data  (arr_data),
                .wr_en_w   (wr_en_w),
                .wr_addr_w (wr_addr_w),
                .wr_data_w (wr_data_w),
`ifdef RF_SCOREBOARD_EN
                .busy_bit  (busy_reg[ra]),
                .rd_busy   (rd_busy_w),
`endif
                .rd_data   (rd_data_w)
            );

            assign bus.rd_data[gi*DATA_W +: DATA_W] = rd_data_w;
`ifdef RF_SCOREBOARD_EN
            assign bus.rd_busy[gi] = rd_busy_w;
`endif
        end
    endgenerate

endmodule

// File: tb/tb_rf_multiport.sv
// Directed bench for rf_multiport: vector table plus reset and scoreboard sequences.
module tb_rf_multiport;

    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_fail;

    rf_multiport_if #(.DATA_W(32), .DEPTH(32), .NUM_RD(2), .NUM_WR(2)) bus ();

    rf_multiport #(
        .DATA_W   (32),
        .DEPTH    (32),
        .NUM_RD   (2),
        .NUM_WR   (2),
        .ZERO_REG (1)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  we;
        logic [4:0]  wa0;
        logic [4:0]  wa1;
        logic [31:0] wd0;
        logic [31:0] wd1;
        logic [1:0]  re;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] e0;
        logic [31:0] e1;
        string       name;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] we, input logic [4:0] wa0, input logic [4:0] wa1,
                         input logic [31:0] wd0, input logic [31:0] wd1,
                         input logic [1:0] re, input logic [4:0] ra0, input logic [4:0] ra1);
        bus.wr_en   = we;
        bus.wr_addr = {wa1, wa0};
        bus.wr_data = {wd1, wd0};
        bus.rd_en   = re;
        bus.rd_addr = {ra1, ra0};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rd(input int k);
        logic [63:0] d;
        d = bus.rd_data;
        return d[k*32 +: 32];
    endfunction

`ifdef RF_SCOREBOARD_EN
    task automatic sb(input logic en, input logic [4:0] addr);
        bus.sb_set_en   = en;
        bus.sb_set_addr = addr;
    endtask
`endif

    initial begin
        #1000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset_n  = 1'b0;
        drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 2'b00, 5'd0, 5'd0);
`ifdef RF_SCOREBOARD_EN
        sb(1'b0, 5'd0);
`endif
        vecs[0]  = '{2'b01, 5'd3,  5'd0,  32'h12345678, 32'h0,        2'b00, 5'd0,  5'd0,  32'h00000000, 32'h00000000, "wr_r3"};
        vecs[1]  = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        2'b11, 5'd3,  5'd3,  32'h12345678, 32'h12345678, "rd_r3_latency"};
        vecs[2]  = '{2'b01, 5'd3,  5'd0,  32'hCAFEF00D, 32'h0,        2'b00, 5'd3,  5'd3,  32'h12345678, 32'h12345678, "hold_on_rewrite"};
        vecs[3]  = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        2'b01, 5'd3,  5'd5,  32'hCAFEF00D, 32'h12345678, "rd_r3_new"};
        vecs[4]  = '{2'b01, 5'd7,  5'd0,  32'hA5A5A5A5, 32'h0,        2'b11, 5'd7,  5'd7,  32'hA5A5A5A5, 32'hA5A5A5A5, "bypass_r7"};
        vecs[5]  = '{2'b01, 5'd0,  5'd0,  32'hFFFFFFFF, 32'h0,        2'b11, 5'd0,  5'd0,  32'h00000000, 32'h00000000, "zero_bypass"};
        vecs[6]  = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        2'b11, 5'd0,  5'd7,  32'h00000000, 32'hA5A5A5A5, "rd_r0_r7"};
        vecs[7]  = '{2'b11, 5'd9,  5'd9,  32'h00001111, 32'h00002222, 2'b11, 5'd9,  5'd9,  32'h00002222, 32'h00002222, "conflict_bypass"};
        vecs[8]  = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        2'b11, 5'd9,  5'd3,  32'h00002222, 32'hCAFEF00D, "rd_r9_r3"};
        vecs[9]  = '{2'b11, 5'd10, 5'd11, 32'hAAAA0000, 32'h0000BBBB, 2'b11, 5'd10, 5'd11, 32'hAAAA0000, 32'h0000BBBB, "dual_distinct"};
        vecs[10] = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        2'b11, 5'd12, 5'd10, 32'h00000000, 32'hAAAA0000, "rd_r12_r10"};
        vecs[11] = '{2'b10, 5'd12, 5'd12, 32'h00000099, 32'h00000077, 2'b11, 5'd12, 5'd0,  32'h00000077, 32'h00000000, "wr1_only_bypass"};
        vecs[12] = '{2'b01, 5'd31, 5'd0,  32'h80000001, 32'h0,        2'b01, 5'd31, 5'd0,  32'h80000001, 32'h00000000, "max_addr_bypass"};
        vecs[13] = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        2'b10, 5'd31, 5'd31, 32'h80000001, 32'h80000001, "rd_r31_port1"};

        repeat (2) tick();
        reset_n = 1'b1;
        repeat (3) tick();
        check("reset_rd0", rd(0), 32'h0);
        check("reset_rd1", rd(1), 32'h0);
`ifdef RF_SCOREBOARD_EN
        check("reset_busy", {30'd0, bus.rd_busy}, 32'h0);
`endif

        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].we, vecs[i].wa0, vecs[i].wa1, vecs[i].wd0, vecs[i].wd1,
                  vecs[i].re, vecs[i].ra0, vecs[i].ra1);
            tick();
            $display("vec %0d %s rd0=%h rd1=%h", i, vecs[i].name, rd(0), rd(1));
            check({vecs[i].name, "_p0"}, rd(0), vecs[i].e0);
            check({vecs[i].name, "_p1"}, rd(1), vecs[i].e1);
        end

        // Reset in the middle of a cycle, with a write held across a reset edge.
        drive(2'b01, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0, 2'b00, 5'd0, 5'd0);
        tick();
        drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 2'b11, 5'd5, 5'd5);
        tick();
        $display("pre-reset read r5 rd0=%h rd1=%h", rd(0), rd(1));
        check("pre_reset_r5", rd(0), 32'hDEADBEEF);
        drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 2'b00, 5'd0, 5'd0);
        #3;
        reset_n = 1'b0;
        #1;
        $display("async reset asserted rd0=%h rd1=%h", rd(0), rd(1));
        check("async_reset_rd0", rd(0), 32'h0);
        check("async_reset_rd1", rd(1), 32'h0);
        drive(2'b01, 5'd6, 5'd0, 32'h00000066, 32'h0, 2'b11, 5'd6, 5'd5);
        tick();
        check("in_reset_rd0", rd(0), 32'h0);
        #3;
        reset_n = 1'b1;
        drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 2'b00, 5'd0, 5'd0);
        repeat (3) tick();
        drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 2'b11, 5'd5, 5'd6);
        tick();
        $display("post-reset read r5/r6 rd0=%h rd1=%h", rd(0), rd(1));
        check("post_reset_r5", rd(0), 32'h0);
        check("post_reset_r6_dropped", rd(1), 32'h0);

`ifdef RF_SCOREBOARD_EN
        drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 2'b00, 5'd0, 5'd0);
        sb(1'b1, 5'd4);
        tick();
        sb(1'b0, 5'd0);
        drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 2'b11, 5'd4, 5'd4);
        tick();
        $display("sb read r4 busy=%b", bus.rd_busy);
        check("sb_busy_r4_p0", {31'd0, bus.rd_busy[0]}, 32'd1);
        check("sb_busy_r4_p1", {31'd0, bus.rd_busy[1]}, 32'd1);
        drive(2'b01, 5'd4, 5'd0, 32'h00000055, 32'h0, 2'b01, 5'd4, 5'd4);
        tick();
        $display("sb write+read r4 busy=%b rd0=%h", bus.rd_busy, rd(0));
        check("sb_clear_bypass_busy", {31'd0, bus.rd_busy[0]}, 32'd0);
        check("sb_clear_bypass_data", rd(0), 32'h00000055);
        sb(1'b1, 5'd4);
        drive(2'b01, 5'd4, 5'd0, 32'h00000066, 32'h0, 2'b01, 5'd4, 5'd4);
        tick();
        sb(1'b0, 5'd0);
        $display("sb set+write r4 busy=%b rd0=%h", bus.rd_busy, rd(0));
        check("sb_set_write_same_edge_busy", {31'd0, bus.rd_busy[0]}, 32'd0);
        drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 2'b01, 5'd4, 5'd4);
        tick();
        $display("sb reread r4 busy=%b rd0=%h", bus.rd_busy, rd(0));
        check("sb_set_wins", {31'd0, bus.rd_busy[0]}, 32'd1);
        check("sb_set_wins_data", rd(0), 32'h00000066);
        sb(1'b1, 5'd8);
        drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 2'b01, 5'd8, 5'd4);
        tick();
        sb(1'b0, 5'd0);
        check("sb_no_set_bypass", {31'd0, bus.rd_busy[0]}, 32'd0);
        drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 2'b01, 5'd8, 5'd4);
        tick();
        $display("sb read r8 busy=%b", bus.rd_busy);
        check("sb_r8_busy", {31'd0, bus.rd_busy[0]}, 32'd1);
        sb(1'b1, 5'd0);
        drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 2'b10, 5'd8, 5'd0);
        tick();
        sb(1'b0, 5'd0);
        drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 2'b10, 5'd8, 5'd0);
        tick();
        $display("sb read r0 busy=%b", bus.rd_busy);
        check("sb_r0_never_busy", {31'd0, bus.rd_busy[1]}, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rf_multiport.md
Name: rf_multiport

Overview:
- Parametrised successor to the single-write, dual-read core register file.
- Configurable data width, register count, read ports and write ports.
- Registered reads with write-through bypass; register 0 hardwired to zero when enabled.
- Sits between decode (read addresses) and writeback (write ports). The multi-write-port build serves the dual-issue and load-writeback datapaths.

Parameters:
- DATA_W, 32, register width in bits
- DEPTH, 32, number of architectural registers (power of 2, ≥2)
- ADDR_W, $clog2(DEPTH), register address width (derived; do not override)
- NUM_RD, 2, number of read ports (1..4)
- NUM_WR, 1, number of write ports (1..2)
- ZERO_REG, 1, 1 = register 0 reads as zero and ignores writes

Ports:
- clk  in  1  rising-edge clock; all state updates on posedge
- reset_n  in  1  asynchronous active-low reset
- rd_en  in  NUM_RD  per-port read enable
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port k at [k*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  packed registered read data
- wr_en  in  NUM_WR  per-port write enable
- wr_addr  in  NUM_WR*ADDR_W  packed write addresses
- wr_data  in  NUM_WR*DATA_W  packed write data
- sb_set_en  in  1  scoreboard: mark sb_set_addr busy (RF_SCOREBOARD_EN only)
- sb_set_addr  in  ADDR_W  scoreboard set address (RF_SCOREBOARD_EN only)
- rd_busy  out  NUM_RD  registered busy flag per read port (RF_SCOREBOARD_EN only)

Behaviour:
- Reset (reset_n low, async assert, sync deassert at top level): all DEPTH registers = 0, rd_data = 0, rd_busy = 0, busy bits = 0.
- Reset mid-operation discards in-flight writes immediately. No write takes effect on the edge where reset_n is low.
- Write: on posedge, for each port j with wr_en[j]=1, reg[wr_addr[j]] <= wr_data[j].
  - ZERO_REG=1 and wr_addr=0: write dropped.
- Write-write conflict (same address, same cycle): highest-index port wins (port 1 over port 0).
- Read latency: 1 cycle. On posedge with rd_en[k]=1, rd_data[k] <= value of reg[rd_addr[k]].
- rd_en[k]=0: rd_data[k] holds its previous value.
- Bypass: if any wr_en[j] with wr_addr[j]==rd_addr[k] on the same edge, rd_data[k] takes the winning wr_data (same priority as the write), not the stale array value.
- ZERO_REG=1 and rd_addr[k]=0: rd_data[k] <= 0 regardless of bypass.
- Multiple read ports on the same address are independent and return identical data.
- Storage is an unpacked array; no reset-less RAM inference is required.

Optional Feature:
- Macro: RF_SCOREBOARD_EN
- Defined: a DEPTH-bit busy vector.
  - sb_set_en sets busy[sb_set_addr] on posedge.
  - Any wr_en[j] clears busy[wr_addr[j]].
  - Set and clear on the same address, same cycle: set wins (a new producer was issued).
  - rd_busy[k] <= busy[rd_addr[k]] with clear-bypass applied, so a same-edge write reports not-busy. Set-bypass is not applied, so a same-edge set reports the pre-set value.
  - rd_busy updates only when rd_en[k]=1.
  - Register 0 is never busy when ZERO_REG=1.
- Undefined: sb_set_en, sb_set_addr and rd_busy ports are absent; no busy storage.

Decomposition:
- Package rf_pkg holds:
  - default DATA_W/DEPTH constants
  - typedef rf_addr_t, rf_data_t
  - function wr_winner(), which returns the bypass hit and winning data given the write vectors and a read address.
- Sub-module rf_read_port: one instance per read port, containing bypass mux, zero-reg masking, enable-hold output register and optional busy flop. Generated NUM_RD times.

Test Plan:
- Reset: write 0xDEADBEEF to r5, assert reset_n=0 mid-cycle → rd_data immediately 0. After release, read r5 → 0x00000000.
- Basic and latency: write r3=0x12345678, then next cycle rd_en=1, rd_addr=3 → rd_data=0x12345678 exactly one posedge later. With rd_en=0 after that, rd_data holds the value even when r3 is rewritten.
- Bypass: same edge wr_addr=7, wr_data=0xA5A5A5A5 and rd_addr[0]=7, rd_addr[1]=7 → both ports show 0xA5A5A5A5 after that edge.
- Zero reg: write r0=0xFFFFFFFF with bypass read of r0 → rd_data=0. Then read r0 → 0.
- Dual write conflict (NUM_WR=2): port0 r9=0x1111, port1 r9=0x2222 same cycle → r9 reads 0x2222, and bypass also returns 0x2222.
- Scoreboard (RF_SCOREBOARD_EN): set r4 busy → read r4 gives rd_busy=1. Then write r4=0x55 → same-edge read gives rd_busy=0, rd_data=0x55. Set+write r4 same cycle → subsequent read rd_busy=1.
